mac_dot_product_sequencer: RTL and testbench
============================================

Name: mac_dot_product_sequencer

Overview:
Sequences one signed 20x18 multiply-accumulate datapath through a complete dot-product job: clear, N accumulate steps, then result hand-off.
- Front end: a start/length command port, with add or subtract mode fixed per job.
- Input side: A/B operand pairs arrive on a valid/ready stream.
- Output side: a 38-bit result leaves on a valid/ready port.
- Placement: sits between a DSP-block MAC and a streaming producer/consumer; the controller owns the clear and subtract controls of the MAC.

Parameters:
A_W, 20, signed width of operand A
B_W, 18, signed width of operand B
P_W, 38, accumulator/result width (A_W+B_W)
LEN_W, 8, width of job length (max 2^LEN_W-1 pairs)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  job request, sampled in IDLE only
len_i  in  LEN_W  number of A/B pairs in job, latched with start_i
subtract_i  in  1  0: P=P+A*B, 1: P=P-A*B; latched with start_i
busy_o  out  1  high in every state except IDLE
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  operand pair accepted when in_valid_i & in_ready_o
a_i  in  A_W  signed operand A
b_i  in  B_W  signed operand B
p_valid_o  out  1  result valid
p_ready_i  in  1  consumer accepts result
p_o  out  P_W  signed accumulated result

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, accumulator=0, remaining count=0, subtract latch=0, busy_o=0, in_ready_o=0, p_valid_o=0, p_o=0.
- Reset asserted mid-job aborts the job immediately; no partial result is emitted.
- States: IDLE, CLEAR, RUN, DONE.
  - IDLE: start_i=1 latches len_i and subtract_i, then goes to CLEAR. start_i outside IDLE is ignored; no queueing.
  - CLEAR: one cycle. Accumulator is set to 0. Next state is RUN if len>0, else DONE.
  - RUN: in_ready_o=1. Each handshake does acc <= acc ± (a_i*b_i) at that edge and decrements remaining. The handshake that takes remaining to 0 moves to DONE on the same edge. in_valid_i=0 stalls with no change.
  - DONE: p_valid_o=1, p_o=acc, both held stable until p_ready_i=1. On handshake, go to IDLE.
- in_ready_o=0 outside RUN.
- Arithmetic: full-precision signed product (A_W+B_W bits), sign-extended to P_W. Sum/difference wraps modulo 2^P_W (two's complement) unless MAC_SAT_EN is defined.
- Latency:
  - start edge to first in_ready_o: 2 cycles.
  - last accepted pair to p_valid_o: 1 cycle.
  - a len=0 job gives p_valid_o with p_o=0 two cycles after start.
- Throughput: one pair per cycle in RUN with in_valid_i held high.
- p_o holds the last result after IDLE is re-entered, until the next CLEAR.
- The accumulator is not observable mid-job except via p_o in DONE.

Optional Feature:
Macro: MAC_SAT_EN
- Defined: each accumulate step saturates to +(2^(P_W-1)-1) or -(2^(P_W-1)). An extra output port sat_o (out, 1) goes high on the first saturating step. sat_o is sticky until the next CLEAR or reset, and is valid alongside p_valid_o.
- Not defined: two's-complement wrap, and no sat_o port.

Decomposition:
- Shared package mac_seq_pkg:
  - state enum typedef (IDLE, CLEAR, RUN, DONE)
  - default width constants A_W/B_W/P_W
  - SAT_MAX/SAT_MIN localparam functions of P_W
- Sub-module mac_accum_core: holds the signed multiply plus accumulator register.
  - Inputs: clk, reset, clr, en, sub, a, b.
  - Output: acc.
  - Same clear/enable/subtract semantics as the DSP MAC, so it can be swapped for the hard primitive.
  - The sequencer contains only the FSM, counter and handshakes.

Test Plan:
1. Reset with start_i held high -> busy_o=0, p_valid_o=0, p_o=0. After release, a job starts normally.
2. start len=1 add, pair (5,2), p_ready_i=1 -> p_o=10 one cycle after the handshake. The same job with subtract_i=1 -> p_o=-10.
3. start len=4 add, pairs (1,1),(2,3),(-4,5),(7,-2) with in_valid_i toggled every other cycle -> p_o=-27; exactly 4 handshakes, in_ready_o=0 after the 4th.
4. len=0 -> p_valid_o with p_o=0 two cycles after start; a start_i pulse during DONE is ignored and busy_o stays 1.
5. Backpressure: p_ready_i=0 for 5 cycles in DONE -> p_valid_o and p_o stable. Release -> IDLE, busy_o=0 next cycle.
6. Reset asserted after 2 of 4 pairs -> immediate IDLE, no p_valid_o. The next len=1 (5,2) job gives 10.
   - MAC_SAT_EN variant: len=2 add, pairs (-524288,-131072) twice -> p_o=2^37-1, sat_o=1.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the dot-product sequencer and its accumulate core.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int A_W_DEF   = 20;
    localparam int B_W_DEF   = 18;
    localparam int P_W_DEF   = A_W_DEF + B_W_DEF;
    localparam int LEN_W_DEF = 8;

    // Saturation rails for the default accumulator width
    localparam logic [P_W_DEF-1:0] SAT_MAX = {1'b0, {(P_W_DEF-1){1'b1}}};
    localparam logic [P_W_DEF-1:0] SAT_MIN = {1'b1, {(P_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_accum_core.sv
// Signed multiply plus accumulator with clear/enable/subtract controls matching the DSP MAC.
// Build option MAC_SAT_EN: saturating accumulate plus sticky sat flag.
module mac_accum_core
    import mac_seq_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  sub,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] acc
`ifdef MAC_SAT_EN
    ,
    output logic                  sat
`endif
);

    localparam int M_W = A_W + B_W;

    logic signed [M_W-1:0] prod;
    logic signed [P_W-1:0] prod_ext;
    logic signed [P_W-1:0] acc_q, acc_d;

    assign prod     = M_W'(a) * M_W'(b);
    assign prod_ext = P_W'(prod);
    assign acc      = acc_q;

`ifdef MAC_SAT_EN
    localparam logic [P_W-1:0] SAT_HI = {1'b0, {(P_W-1){1'b1}}};
    localparam logic [P_W-1:0] SAT_LO = {1'b1, {(P_W-1){1'b0}}};

    logic [P_W:0] wide;
    logic         ovf;
    logic         sat_q, sat_d;

    // One guard bit exposes overflow: the top two bits disagree
    always_comb begin
        wide = sub ? ({acc_q[P_W-1], acc_q} - {prod_ext[P_W-1], prod_ext})
                   : ({acc_q[P_W-1], acc_q} + {prod_ext[P_W-1], prod_ext});
        ovf  = wide[P_W] ^ wide[P_W-1];
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (en) begin
            acc_d = ovf ? (wide[P_W] ? SAT_LO : SAT_HI) : wide[P_W-1:0];
            sat_d = sat_q | ovf;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign sat = sat_q;
`else
    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

endmodule

// File: rtl/mac_dot_product_sequencer.sv
// Dot-product job controller: clear, N streamed multiply-accumulates, then result hand-off.
// Build option MAC_SAT_EN adds saturating arithmetic and the sat_o output.
module mac_dot_product_sequencer
    import mac_seq_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int P_W   = P_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic                  subtract_i,
    output logic                  busy_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic                  p_valid_o,
    input  logic                  p_ready_i,
    output logic signed [P_W-1:0] p_o
`ifdef MAC_SAT_EN
    ,
    output logic                  sat_o
`endif
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               sub_q, sub_d;
    logic               acc_clr, acc_en;
    logic signed [P_W-1:0] acc;

    mac_accum_core #(
        .A_W(A_W),
        .B_W(B_W),
        .P_W(P_W)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .clr  (acc_clr),
        .en   (acc_en),
        .sub  (sub_q),
        .a    (a_i),
        .b    (b_i),
        .acc  (acc)
`ifdef MAC_SAT_EN
        ,
        .sat  (sat_o)
`endif
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sub_d      = sub_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        busy_o     = 1'b1;
        in_ready_o = 1'b0;
        p_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    rem_d   = len_i;
                    sub_d   = subtract_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr = 1'b1;
                state_d = (rem_q != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    acc_en = 1'b1;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                p_valid_o = 1'b1;
                if (p_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sub_q   <= sub_d;
        end
    end

    // Partial sums stay hidden while accumulating; the last result persists until CLEAR
    assign p_o = (state_q == RUN) ? '0 : acc;

endmodule

// File: tb/tb_mac_dot_product_sequencer.sv
// Directed self-checking bench for mac_dot_product_sequencer (optionally built with MAC_SAT_EN).
module tb_mac_dot_product_sequencer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start_i = 1'b0;
    logic [7:0]         len_i = '0;
    logic               subtract_i = 1'b0;
    logic               busy_o;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic signed [19:0] a_i = '0;
    logic signed [17:0] b_i = '0;
    logic               p_valid_o;
    logic               p_ready_i = 1'b0;
    logic signed [37:0] p_o;
`ifdef MAC_SAT_EN
    logic               sat_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;

    mac_dot_product_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .len_i     (len_i),
        .subtract_i(subtract_i),
        .busy_o    (busy_o),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .p_valid_o (p_valid_o),
        .p_ready_i (p_ready_i),
        .p_o       (p_o)
`ifdef MAC_SAT_EN
        ,
        .sat_o     (sat_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid_i && in_ready_o) hs_cnt <= hs_cnt + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns one negedge later with the DUT in CLEAR
    task automatic do_start(input logic [7:0] len, input logic sub);
        start_i = 1'b1;
        len_i = len;
        subtract_i = sub;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the pair was accepted
    task automatic send(input logic signed [19:0] a, input logic signed [17:0] b);
        int t = 0;
        while (!in_ready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", (t < 20) ? 1 : 0, 1);
        in_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        @(negedge clk);
        in_valid_i = 1'b0;
        $display("pair a=%0d b=%0d sent, p_valid=%0b", a, b, p_valid_o);
    endtask

    task automatic accept(input string tag);
        p_ready_i = 1'b1;
        @(negedge clk);
        p_ready_i = 1'b0;
        check(tag, busy_o, 0);
        $display("result accepted, p_o=%0d busy=%0b", p_o, busy_o);
    endtask

    initial begin
        int h0;
        logic seen_valid;
        logic signed [19:0] va [4];
        logic signed [17:0] vb [4];
        va = '{20'sd1, 20'sd2, -20'sd4, 20'sd7};
        vb = '{18'sd1, 18'sd3, 18'sd5, -18'sd2};

        // 1: reset with start held high
        reset = 1'b1; start_i = 1'b1; len_i = 8'd1; subtract_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_p_valid", p_valid_o, 0);
        check("rst_p_o", p_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        reset = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        check("t2_clear_busy", busy_o, 1);
        check("t2_clear_ready", in_ready_o, 0);
        @(negedge clk);
        check("t2_first_ready", in_ready_o, 1);

        // 2: single pair add, then subtract
        send(20'sd5, 18'sd2);
        check("t2_p_valid", p_valid_o, 1);
        check("t2_add", p_o, 10);
`ifdef MAC_SAT_EN
        check("t2_no_sat", sat_o, 0);
`endif
        accept("t2_idle");
        do_start(8'd1, 1'b1);
        send(20'sd5, 18'sd2);
        check("t2s_p_valid", p_valid_o, 1);
        check("t2_sub", p_o, -10);
        accept("t2s_idle");

        // 3: four pairs with in_valid toggling
        do_start(8'd4, 1'b0);
        h0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i]);
            if (i < 3) @(negedge clk);
        end
        check("t3_ready_low", in_ready_o, 0);
        check("t3_p_valid", p_valid_o, 1);
        check("t3_p_o", p_o, -27);
        check("t3_handshakes", hs_cnt - h0, 4);
        in_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        in_valid_i = 1'b0;
        check("t3_no_extra_hs", hs_cnt - h0, 4);
        check("t3_p_o_hold", p_o, -27);
        accept("t3_idle");

        // 4: zero-length job and start ignored in DONE
        do_start(8'd0, 1'b0);
        check("t4_clear_no_valid", p_valid_o, 0);
        @(negedge clk);
        check("t4_p_valid", p_valid_o, 1);
        check("t4_p_o", p_o, 0);
        start_i = 1'b1; len_i = 8'd3;
        @(negedge clk);
        start_i = 1'b0;
        check("t4_busy_done", busy_o, 1);
        check("t4_valid_done", p_valid_o, 1);
        accept("t4_idle");
        @(negedge clk);
        check("t4_no_queue", busy_o, 0);

        // 5: result backpressure
        do_start(8'd1, 1'b0);
        send(20'sd3, -18'sd4);
        for (int i = 0; i < 5; i++) begin
            check("t5_valid_hold", p_valid_o, 1);
            check("t5_p_o_hold", p_o, -12);
            @(negedge clk);
        end
        accept("t5_idle");
        check("t5_valid_off", p_valid_o, 0);
        check("t5_p_o_idle", p_o, -12);

        // 6: reset mid-job
        do_start(8'd4, 1'b0);
        send(20'sd1, 18'sd1);
        send(20'sd2, 18'sd2);
        reset = 1'b1;
        #1;
        check("t6_busy", busy_o, 0);
        check("t6_ready", in_ready_o, 0);
        check("t6_p_valid", p_valid_o, 0);
        check("t6_p_o", p_o, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_valid = seen_valid | p_valid_o;
        end
        check("t6_no_partial", seen_valid, 0);
        do_start(8'd1, 1'b0);
        send(20'sd5, 18'sd2);
        check("t6_p_valid_after", p_valid_o, 1);
        check("t6_p_o_after", p_o, 10);
        accept("t6_idle");

`ifdef MAC_SAT_EN
        do_start(8'd2, 1'b0);
        send(-20'sd524288, -18'sd131072);
        send(-20'sd524288, -18'sd131072);
        check("sat_p_valid", p_valid_o, 1);
        check("sat_p_o", p_o, 64'sd137438953471);
        check("sat_flag", sat_o, 1);
        accept("sat_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
